// File: rtl/seven_segmentos.sv
// Registered hex-to-seven-segment decoder for one display digit.
// Segment order in every 7-bit vector is {g, f, e, d, c, b, a}.
// ACTIVE_LOW selects common-anode (lit = 0) or common-cathode (lit = 1) drive.
module seven_segmentos #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  output logic [6:0] display
);

  // All segments off, in the selected polarity.
  localparam logic [6:0] Blank = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  logic [6:0] mask;       // lit-segment mask, active-high
  logic       known;      // data carries no X/Z bits
  logic [6:0] display_d;
  logic [6:0] display_q;

  // Nibble to lit-segment lookup. Case items only match fully known values,
  // so an X/Z nibble falls through to the default and lights nothing.
  always_comb begin
    mask  = 7'h00;
    known = 1'b1;
    case (data)
      4'h0:    mask = 7'h3F;
      4'h1:    mask = 7'h06;
      4'h2:    mask = 7'h5B;
      4'h3:    mask = 7'h4F;
      4'h4:    mask = 7'h66;
      4'h5:    mask = 7'h6D;
      4'h6:    mask = 7'h7D;
      4'h7:    mask = 7'h07;
      4'h8:    mask = 7'h7F;
      4'h9:    mask = 7'h6F;
      4'hA:    mask = 7'h77;  // uppercase A
      4'hB:    mask = 7'h7C;  // lowercase b
      4'hC:    mask = 7'h39;  // uppercase C
      4'hD:    mask = 7'h5E;  // lowercase d
      4'hE:    mask = 7'h79;  // uppercase E
      4'hF:    mask = 7'h71;  // uppercase F
      default: known = 1'b0;  // only reachable with X/Z on data
    endcase
  end

  // Apply segment polarity; an unknown nibble shows the blank pattern.
  always_comb begin
    display_d = Blank;
    if (known) begin
      display_d = ACTIVE_LOW ? ~mask : mask;
    end
  end

  // Output register with synchronous active-low reset to blank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_q <= Blank;
    end else begin
      display_q <= display_d;
    end
  end

  assign display = display_q;

endmodule

// File: tb/tb_seven_segmentos.sv
// Self-checking bench for seven_segmentos: both polarities driven in parallel,
// checked against a segment-shape reference model.
module tb_seven_segmentos;

  logic       clk;
  logic       rst_n;
  logic [3:0] data;
  logic [6:0] disp_al;  // ACTIVE_LOW = 1 instance
  logic [6:0] disp_ah;  // ACTIVE_LOW = 0 instance

  int checks;
  int failures;

  seven_segmentos #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .display(disp_al)
  );

  seven_segmentos #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .display(disp_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each glyph as the set of lit segment letters.
  string shapes [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  // Active-high lit mask, bit n = segment letter 'a'+n.
  function automatic logic [6:0] lit(input logic [3:0] v);
    logic [6:0] m;
    string      s;
    m = '0;
    s = shapes[v];
    for (int i = 0; i < s.len(); i++) begin
      m[int'(s[i]) - int'("a")] = 1'b1;
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Expected outputs after the next edge, from the inputs present at that edge.
  logic [6:0] exp_al;
  logic [6:0] exp_ah;

  task automatic tick(input string tag);
    if (!rst_n) begin
      exp_al = 7'b1111111;
      exp_ah = 7'b0000000;
    end else begin
      exp_ah = lit(data);
      exp_al = ~exp_ah;
    end
    @(posedge clk);
    #1;
    check({tag, "_al"}, disp_al, exp_al);
    check({tag, "_ah"}, disp_ah, exp_ah);
  endtask

  logic probe;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    data     = 4'h8;
    @(posedge clk);
    #1;

    // Reset held two edges with data = 8, then release.
    check("reset_first_edge", disp_al, 7'b1111111);
    tick("reset_hold");
    check("reset_hold_lit", disp_al, 7'b1111111);
    rst_n = 1'b1;
    tick("reset_release");
    check("reset_release_lit", disp_al, 7'b0000000);

    // Full sweep 0..F, one nibble per cycle.
    for (int v = 0; v < 16; v++) begin
      data = 4'(v);
      tick($sformatf("sweep_%h", v));
    end

    // Latency: data changes mid-cycle, output waits for the edge.
    data = 4'h1;
    tick("lat_one");
    #2;
    data = 4'h7;
    #1;
    check("lat_hold", disp_al, 7'b1111001);
    tick("lat_seven");
    check("lat_seven_lit", disp_al, 7'b1111000);

    // Reset mid-stream while decoding A.
    data = 4'hA;
    tick("mid_a");
    rst_n = 1'b0;
    tick("mid_reset");
    check("mid_reset_lit", disp_al, 7'b1111111);
    rst_n = 1'b1;
    tick("mid_recover");
    check("mid_recover_lit", disp_al, 7'b0001000);

    // Randomized stream with occasional reset pulses.
    for (int n = 0; n < 60; n++) begin
      data  = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 7) != 0);
      tick($sformatf("rand_%0d", n));
    end
    rst_n = 1'b1;

    // Unknown input: blank on a four-state simulator; a two-state simulator
    // resolves the X bits, so expect the decode of the resolved value there.
    probe = 1'bx;
    data  = 4'bxx01;
    @(posedge clk);
    #1;
    if ($isunknown(probe)) begin
      check("unknown_al", disp_al, 7'b1111111);
      check("unknown_ah", disp_ah, 7'b0000000);
    end else begin
      check("unknown_al", disp_al, ~lit(data));
      check("unknown_ah", disp_ah, lit(data));
    end
    checks++;
    assert (!$isunknown({disp_al, disp_ah})) else begin
      failures++;
      $error("FAIL unknown_no_x observed=%b_%b expected=no X bits", disp_al, disp_ah);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segmentos.md
# seven_segmentos

Registered hexadecimal-to-seven-segment decoder. It converts a 4-bit nibble (0–F) into the segment pattern for one digit of a seven-segment display, including the letters A, b, C, d, E and F. It sits between the datapath that produces the nibble and the display pins; in a multi-digit display it is instantiated once per digit, upstream of the digit multiplexer. The output is registered so the segment pins are glitch-free.

## Interface

- `ACTIVE_LOW`, default 1: segment polarity.
  - 1 means a lit segment is driven 0 (common-anode).
  - 0 means a lit segment is driven 1 (common-cathode).
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  reset; one clock, reset is synchronous and active-low.
- `data`  input  4  nibble to display, unsigned 0x0–0xF.
- `display`  output  7  segment drive, registered. Bit mapping:
  - `display[0]`=a, `[1]`=b, `[2]`=c, `[3]`=d, `[4]`=e, `[5]`=f, `[6]`=g.
  - Standard lettering: a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle.
  - No decimal point.

## Operation

- The combinational lookup maps `data` to a lit-segment mask, written as active-high g..a in hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Letters use these shapes: uppercase A, lowercase b, uppercase C, lowercase d, uppercase E, uppercase F.
- Polarity handling:
  - `ACTIVE_LOW`=1: `display` is the bitwise inverse of the mask. For example, 0 → 7'b1000000 and 8 → 7'b0000000.
  - `ACTIVE_LOW`=0: `display` equals the mask.
- All 16 codes are defined. There is no default/blank case reachable for legal 4-bit values.
- Unknown inputs: if `data` contains X/Z, the decoder must drive the blank pattern rather than propagate a partial decode. This is simulation-only behaviour; a synthesis don't-care is acceptable.
- Blank pattern means all segments off: 7'b1111111 when `ACTIVE_LOW`=1, 7'b0000000 when `ACTIVE_LOW`=0.
- The decoder keeps no other state: no enable, no latching of previous values beyond the output register.

## Timing

- Output register:
  - On each rising `clk`, `display` <= decode(`data`) when `rst_n`=1.
  - On each rising `clk`, `display` <= blank pattern when `rst_n`=0.
- Latency is exactly 1 cycle from `data` to `display`. Throughput is one new nibble per cycle.
- Reset value:
  - `display` = blank (all segments off) on the first rising edge with `rst_n`=0.
  - The value before the first clock edge is undefined.
- Reset is synchronous only. Asserting or deasserting `rst_n` between edges has no effect until the next rising edge.
- Reset mid-stream: the cycle after the reset edge shows blank. The first edge with `rst_n`=1 loads decode(`data`) present at that edge, with no extra recovery cycle.
- If `data` changes every cycle, `display` follows with a 1-cycle delay. No intermediate/glitch values appear on `display`.

## Test plan

- **Reset:** hold `rst_n`=0 for 2 cycles with `data`=4'h8.
  - Required: `display`=7'b1111111 (`ACTIVE_LOW`=1) after the first edge.
  - Required: it stays blank until the edge after `rst_n`=1, then becomes 7'b0000000.
- **Full sweep, `ACTIVE_LOW`=1:** apply `data`=0..F, one per cycle. Required `display` one cycle later, in order:
  - 40, 79, 24, 30, 19, 12, 02, 78
  - 00, 10, 08, 03, 46, 21, 06, 0E
  - (hex, bit 6 = g)
- **Full sweep, `ACTIVE_LOW`=0:** the same sweep must give:
  - 3F, 06, 5B, 4F, 66, 6D, 7D, 07
  - 7F, 6F, 77, 7C, 39, 5E, 79, 71
- **Latency:** change `data` from 4'h1 to 4'h7 mid-cycle.
  - Required: `display` stays 7'b1111001 until the next rising edge, then becomes 7'b1111000 (`ACTIVE_LOW`=1).
- **Reset mid-stream:** while `data`=4'hA is decoding, pull `rst_n` low for one edge.
  - Required: `display`=7'b1111111 for exactly that cycle.
  - Required: `display`=7'b0001000 on the following edge with `rst_n`=1.
- **Unknown input:** drive `data`=4'bxx01 with `rst_n`=1.
  - Required: `display`=blank (7'b1111111) after the next edge, with no X bits on `display`.
